// File: rtl/usb_up_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_up_pkg
//  Description : Shared constants for the FX3 upload arbiter: header layout,
//                pad word, FSM state encoding and a header builder.
//  Revision    : 1.0  initial release
// ============================================================================
package usb_up_pkg;

    // Header word layout: {magic[31:16], 7'd0, flush[8], 5'd0, chan[2:0]}
    localparam logic [15:0] c_hdr_magic     = 16'hA55A;
    localparam int          c_hdr_magic_lsb = 16;
    localparam int          c_hdr_flush_bit = 8;
    localparam int          c_hdr_chan_lsb  = 0;

    // Word appended after a short flush burst, carries pktend
    localparam logic [31:0] c_pad_word      = 32'h0000_0000;

    // Arbiter FSM encoding
    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_grant     = 3'd1;
    localparam logic [2:0] c_st_hdr       = 3'd2;
    localparam logic [2:0] c_st_burst     = 3'd3;
    localparam logic [2:0] c_st_flush_end = 3'd4;
    localparam logic [2:0] c_st_end       = 3'd5;

    // Build the channel header word that precedes every burst
    function automatic logic [31:0] make_header(input logic flush, input logic [2:0] chan);
        logic [31:0] hdr;
        hdr                              = '0;
        hdr[c_hdr_magic_lsb +: 16]       = c_hdr_magic;
        hdr[c_hdr_flush_bit]             = flush;
        hdr[c_hdr_chan_lsb +: 3]         = chan;
        return hdr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_up_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : usb_up_arbiter_if
//  Description : Source-FIFO side and slave-FIFO controller side signals of
//                the upload arbiter. master = arbiter, slave = environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface usb_up_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int DW      = 32
);
    logic [NUM_SRC-1:0]    src_valid;
    logic [NUM_SRC-1:0]    src_level_ok;
    logic [NUM_SRC*DW-1:0] src_data;
    logic [NUM_SRC-1:0]    src_rden;
    logic                  up_ready;
    logic                  out_valid;
    logic [DW-1:0]         out_data;
    logic                  out_pktend;
    logic [2:0]            out_chan;

    modport master (
        input  src_valid, src_level_ok, src_data, up_ready,
        output src_rden, out_valid, out_data, out_pktend, out_chan
    );

    modport slave (
        output src_valid, src_level_ok, src_data, up_ready,
        input  src_rden, out_valid, out_data, out_pktend, out_chan
    );
endinterface
`default_nettype wire

// File: rtl/usb_up_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational circular priority encoder. Returns the first
//                set request at or after ptr, wrapping at NUM_SRC.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_SRC = 4
) (
    input  wire logic [NUM_SRC-1:0] req,
    input  wire logic [2:0]         ptr,
    output logic      [2:0]         idx,
    output logic                    found
);

    logic [2*NUM_SRC-1:0] w_dbl;
    logic [NUM_SRC-1:0]   w_rot;
    logic [3:0]           w_sum;

    // Rotate the request vector so ptr lands on bit 0, then take the lowest set bit
    always_comb begin
        w_dbl = {req, req};
        w_rot = NUM_SRC'(w_dbl >> ptr);
        idx   = 3'd0;
        found = 1'b0;
        w_sum = 4'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && w_rot[k]) begin
                found = 1'b1;
                w_sum = {1'b0, ptr} + 4'(k);
                if (w_sum >= 4'(NUM_SRC)) begin
                    w_sum = w_sum - 4'(NUM_SRC);
                end
                idx = w_sum[2:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_up_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : usb_up_arbiter
//  Description : Round-robin burst arbiter sharing the FX3 EP2 upload stream
//                among NUM_SRC show-ahead FIFOs. Each burst is prefixed by a
//                channel header; stale partial data is flushed as a short
//                packet terminated by a pad word with pktend.
//  Revision    : 1.0  initial release
// ============================================================================
module usb_up_arbiter
    import usb_up_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int DW          = 32,
    parameter int BURST_WORDS = 4096,
    parameter int TIMEOUT     = 1024
) (
    input  wire logic         clk_100,
    input  wire logic         reset_,
    input  wire logic         en,
    usb_up_arbiter_if.master  bus,
    output logic              busy,
    output logic              burst_done,
    output logic [15:0]       burst_count
);

    localparam int WCW = $clog2(BURST_WORDS + 1);
    localparam int ICW = $clog2(TIMEOUT + 1);

    logic [2:0]         r_state;
    logic [2:0]         r_chan;
    logic [2:0]         r_rr_ptr;
    logic               r_flush;
    logic [WCW-1:0]     r_word_cnt;
    logic [ICW-1:0]     r_idle_cnt;
    logic [15:0]        r_burst_count;

    logic               w_lvl_any;
    logic [2:0]         w_lvl_idx;
    logic               w_vld_any;
    logic [2:0]         w_vld_idx;
    logic               w_cur_valid;
    logic [DW-1:0]      w_cur_data;
    logic               w_timeout_hit;
    logic               w_last_word;
    logic               w_xfer;
    logic               w_out_valid;
    logic [DW-1:0]      w_out_data;
    logic               w_out_pktend;
    logic [NUM_SRC-1:0] w_rden;

    rr_pick #(.NUM_SRC(NUM_SRC)) u_pick_lvl (
        .req   (bus.src_level_ok),
        .ptr   (r_rr_ptr),
        .idx   (w_lvl_idx),
        .found (w_lvl_any)
    );

    rr_pick #(.NUM_SRC(NUM_SRC)) u_pick_vld (
        .req   (bus.src_valid),
        .ptr   (r_rr_ptr),
        .idx   (w_vld_idx),
        .found (w_vld_any)
    );

    // Select the granted source's show-ahead head word and valid
    always_comb begin
        w_cur_valid = 1'b0;
        w_cur_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_chan == 3'(i)) begin
                w_cur_valid = bus.src_valid[i];
                w_cur_data  = bus.src_data[i*DW +: DW];
            end
        end
    end

    assign w_timeout_hit = (r_idle_cnt == ICW'(TIMEOUT - 1));
    assign w_last_word   = (r_word_cnt == WCW'(BURST_WORDS - 1));

    // Output word mux: header, FIFO data or pad depending on phase
    always_comb begin
        w_out_valid  = 1'b0;
        w_out_data   = '0;
        w_out_pktend = 1'b0;
        case (r_state)
            c_st_hdr: begin
                w_out_valid = 1'b1;
                w_out_data  = DW'(make_header(r_flush, r_chan));
            end
            c_st_burst: begin
                w_out_valid = w_cur_valid;
                w_out_data  = w_cur_data;
            end
            c_st_flush_end: begin
                w_out_valid  = 1'b1;
                w_out_data   = DW'(c_pad_word);
                w_out_pktend = 1'b1;
            end
            default: begin
                w_out_valid = 1'b0;
            end
        endcase
    end

    assign w_xfer = w_out_valid && bus.up_ready;

    // Zero-latency read strobe: pops the granted FIFO on each accepted data word
    always_comb begin
        w_rden = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_rden[i] = (r_state == c_st_burst) && w_xfer && (r_chan == 3'(i));
        end
    end

    assign bus.src_rden   = w_rden;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = w_out_data;
    assign bus.out_pktend = w_out_pktend;
    assign bus.out_chan   = r_chan;
    assign busy           = (r_state != c_st_idle);
    assign burst_done     = (r_state == c_st_end);
    assign burst_count    = r_burst_count;

    // Arbitration FSM, burst word counter and starvation timer
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            r_state       <= c_st_idle;
            r_chan        <= 3'd0;
            r_rr_ptr      <= 3'd0;
            r_flush       <= 1'b0;
            r_word_cnt    <= '0;
            r_idle_cnt    <= '0;
            r_burst_count <= 16'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    // Timer only runs while partial data waits with nobody full
                    if (!w_lvl_any && w_vld_any) begin
                        if (!w_timeout_hit) begin
                            r_idle_cnt <= r_idle_cnt + ICW'(1);
                        end
                    end else begin
                        r_idle_cnt <= '0;
                    end
                    if (en) begin
                        if (w_lvl_any) begin
                            r_chan     <= w_lvl_idx;
                            r_flush    <= 1'b0;
                            r_idle_cnt <= '0;
                            r_state    <= c_st_grant;
                        end else if (w_vld_any && w_timeout_hit) begin
                            r_chan     <= w_vld_idx;
                            r_flush    <= 1'b1;
                            r_idle_cnt <= '0;
                            r_state    <= c_st_grant;
                        end
                    end
                end
                c_st_grant: begin
                    r_state <= c_st_hdr;
                end
                c_st_hdr: begin
                    if (bus.up_ready) begin
                        r_word_cnt <= '0;
                        r_state    <= c_st_burst;
                    end
                end
                c_st_burst: begin
                    if (w_xfer) begin
                        r_word_cnt <= r_word_cnt + WCW'(1);
                        if (w_last_word) begin
                            r_state <= c_st_end;
                        end
                    end else if (r_flush && !w_cur_valid && (r_word_cnt != '0)) begin
                        // Source ran dry before a full burst: close the short packet
                        r_state <= c_st_flush_end;
                    end
                end
                c_st_flush_end: begin
                    if (bus.up_ready) begin
                        r_state <= c_st_end;
                    end
                end
                c_st_end: begin
                    r_burst_count <= r_burst_count + 16'd1;
                    r_rr_ptr      <= (r_chan == 3'(NUM_SRC - 1)) ? 3'd0 : r_chan + 3'd1;
                    r_state       <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_up_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_up_arbiter
//  Description : Self-checking bench for usb_up_arbiter. Source FIFOs are
//                modelled as queues; a scoreboard predicts every output word
//                of each burst from the arbitration rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_usb_up_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int BW = 4096;
    localparam int TO = 1024;

    typedef struct packed {
        logic [31:0] data;
        logic        pktend;
        logic        is_data;
    } exp_t;

    logic        clk_100 = 1'b0;
    logic        reset_;
    logic        en;
    logic        busy;
    logic        burst_done;
    logic [15:0] burst_count;

    usb_up_arbiter_if #(.NUM_SRC(NS), .DW(DW)) bus ();

    usb_up_arbiter #(
        .NUM_SRC     (NS),
        .DW          (DW),
        .BURST_WORDS (BW),
        .TIMEOUT     (TO)
    ) dut (
        .clk_100     (clk_100),
        .reset_      (reset_),
        .en          (en),
        .bus         (bus),
        .busy        (busy),
        .burst_done  (burst_done),
        .burst_count (burst_count)
    );

    always #5 clk_100 = ~clk_100;

    logic [31:0] srcq [NS][$];
    exp_t        exp_q[$];
    int          hdr_log[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_rr, m_count, m_chan, m_data_seen;
    bit          m_active, done_pending, rdy_rand;
    logic [31:0] last_hdr;
    int          xfers, pktends, steps, hdr_step;
    int          ord2[5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < NS; i++) begin
            bus.src_valid[i]         = (srcq[i].size() > 0);
            bus.src_level_ok[i]      = (srcq[i].size() >= BW);
            bus.src_data[i*DW +: DW] = (srcq[i].size() > 0) ? srcq[i][0] : 32'h0;
        end
    endtask

    task automatic load(input int s, input int n);
        for (int k = 0; k < n; k++) srcq[s].push_back($urandom);
        drive_src();
    endtask

    // Decide the next burst from queue fill levels and the round-robin pointer
    task automatic predict_burst();
        int g;
        int n;
        bit fl;
        g  = -1;
        fl = 1'b0;
        for (int k = 0; k < NS; k++) begin
            int j = (m_rr + k) % NS;
            if (g < 0 && srcq[j].size() >= BW) g = j;
        end
        if (g < 0) begin
            fl = 1'b1;
            for (int k = 0; k < NS; k++) begin
                int j = (m_rr + k) % NS;
                if (g < 0 && srcq[j].size() > 0) g = j;
            end
        end
        if (g < 0) begin
            chk("spurious_hdr", 32'd1, 32'd0);
            return;
        end
        m_chan      = g;
        m_active    = 1'b1;
        m_data_seen = 0;
        exp_q.push_back(exp_t'{data: 32'hA55A_0000 | (32'(fl) << 8) | 32'(g), pktend: 1'b0, is_data: 1'b0});
        n = fl ? ((srcq[g].size() < BW) ? srcq[g].size() : BW) : BW;
        for (int k = 0; k < n; k++)
            exp_q.push_back(exp_t'{data: srcq[g][k], pktend: 1'b0, is_data: 1'b1});
        if (fl && n < BW)
            exp_q.push_back(exp_t'{data: 32'h0, pktend: 1'b1, is_data: 1'b0});
    endtask

    // One clock: sample/check at negedge, then apply FIFO pops and new inputs
    task automatic step();
        logic [NS-1:0] rd;
        bit            xfer;
        exp_t          e;
        @(negedge clk_100);
        rd   = bus.src_rden;
        xfer = bus.out_valid && bus.up_ready;
        chk("rden_onehot0", 32'($onehot0(rd)), 32'd1);
        chk("burst_done", 32'(burst_done), 32'(done_pending));
        if (done_pending) begin
            chk("burst_count_at_end", 32'(burst_count), 32'(m_count));
            m_count      = (m_count + 1) % 65536;
            m_rr         = (m_chan + 1) % NS;
            done_pending = 1'b0;
            m_active     = 1'b0;
        end
        if (xfer) begin
            xfers++;
            if (bus.out_pktend) pktends++;
            if (!m_active) begin
                predict_burst();
                hdr_log.push_back(int'(bus.out_chan));
                last_hdr = bus.out_data;
                hdr_step = steps;
            end
            if (exp_q.size() == 0) begin
                chk("extra_word", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", bus.out_data, e.data);
                chk("out_pktend", 32'(bus.out_pktend), 32'(e.pktend));
                chk("src_rden", 32'(rd), e.is_data ? (32'd1 << m_chan) : 32'd0);
                chk("out_chan", 32'(bus.out_chan), 32'(m_chan));
                if (e.is_data) m_data_seen++;
                if (exp_q.size() == 0) done_pending = 1'b1;
            end
        end else begin
            chk("src_rden_noxfer", 32'(rd), 32'd0);
        end
        @(posedge clk_100);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (rd[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        end
        steps++;
        bus.up_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        drive_src();
    endtask

    task automatic run_until(input int target, input int budget);
        int b = budget;
        while (m_count < target && b > 0) begin
            step();
            b--;
        end
        if (m_count < target) chk("run_timeout", 32'(m_count), 32'(target));
    endtask

    // Assert reset, verify outputs clear at once, then release
    task automatic do_reset(input string tag);
        reset_ = 1'b0;
        #1;
        chk({tag, "_out_valid"},   32'(bus.out_valid), 32'd0);
        chk({tag, "_out_data"},    bus.out_data, 32'd0);
        chk({tag, "_out_pktend"},  32'(bus.out_pktend), 32'd0);
        chk({tag, "_src_rden"},    32'(bus.src_rden), 32'd0);
        chk({tag, "_out_chan"},    32'(bus.out_chan), 32'd0);
        chk({tag, "_busy"},        32'(busy), 32'd0);
        chk({tag, "_burst_done"},  32'(burst_done), 32'd0);
        chk({tag, "_burst_count"}, 32'(burst_count), 32'd0);
        for (int i = 0; i < NS; i++) srcq[i].delete();
        exp_q.delete();
        m_rr = 0; m_count = 0; m_chan = 0; m_data_seen = 0;
        m_active = 1'b0; done_pending = 1'b0;
        drive_src();
        repeat (3) @(posedge clk_100);
        #1;
        reset_ = 1'b1;
    endtask

    initial begin
        int s;
        int n;
        int b;
        en           = 1'b1;
        rdy_rand     = 1'b0;
        bus.up_ready = 1'b1;
        steps        = 0;
        for (int i = 0; i < NS; i++) srcq[i].delete();
        drive_src();
        do_reset("rst0");

        // Sources 0 and 2 full: two back-to-back bursts
        hdr_log.delete(); xfers = 0;
        load(0, BW); load(2, BW);
        run_until(2, 3 * (BW + 10));
        chk("t1_burst_count", 32'(burst_count), 32'd2);
        chk("t1_hdr_last", last_hdr, 32'hA55A_0002);
        chk("t1_xfers", 32'(xfers), 32'(2 * (BW + 1)));
        chk("t1_nhdr", 32'(hdr_log.size()), 32'd2);
        if (hdr_log.size() == 2) begin
            chk("t1_order0", 32'(hdr_log[0]), 32'd0);
            chk("t1_order1", 32'(hdr_log[1]), 32'd2);
        end

        // All four full: round-robin 0,1,2,3,0
        do_reset("rst1");
        hdr_log.delete(); xfers = 0;
        load(0, 2 * BW); load(1, BW); load(2, BW); load(3, BW);
        run_until(5, 6 * (BW + 10));
        chk("t2_xfers", 32'(xfers), 32'(5 * (BW + 1)));
        chk("t2_nhdr", 32'(hdr_log.size()), 32'd5);
        for (int i = 0; i < hdr_log.size() && i < 5; i++)
            chk("t2_order", 32'(hdr_log[i]), 32'(ord2[i]));

        // Timeout flush: src1 holds 10 words only
        hdr_log.delete(); xfers = 0; pktends = 0; steps = 0;
        load(1, 10);
        run_until(6, TO + 100);
        chk("t3_hdr", last_hdr, 32'hA55A_0101);
        chk("t3_latency", 32'(hdr_step), 32'(TO + 1));
        chk("t3_xfers", 32'(xfers), 32'd12);
        chk("t3_pktends", 32'(pktends), 32'd1);
        chk("t3_burst_count", 32'(burst_count), 32'd6);

        // Full burst with up_ready toggling randomly
        rdy_rand = 1'b1;
        hdr_log.delete(); xfers = 0;
        s = $urandom_range(0, NS - 1);
        load(s, BW);
        run_until(m_count + 1, 4 * BW);
        chk("t4_xfers", 32'(xfers), 32'(BW + 1));
        if (hdr_log.size() > 0) chk("t4_chan", 32'(hdr_log[0]), 32'(s));

        // Random short flushes under random backpressure
        for (int r = 0; r < 3; r++) begin
            xfers = 0; pktends = 0;
            s = $urandom_range(0, NS - 1);
            n = $urandom_range(1, 20);
            load(s, n);
            run_until(m_count + 1, TO + 200);
            chk("t5_xfers", 32'(xfers), 32'(n + 2));
            chk("t5_pktends", 32'(pktends), 32'd1);
        end
        rdy_rand = 1'b0;

        // A full source beats a pending flush
        hdr_log.delete();
        load(0, 5);
        repeat (600) step();
        load(2, BW);
        run_until(m_count + 2, 2 * BW);
        chk("t6_nhdr", 32'(hdr_log.size()), 32'd2);
        if (hdr_log.size() == 2) begin
            chk("t6_first", 32'(hdr_log[0]), 32'd2);
            chk("t6_second", 32'(hdr_log[1]), 32'd0);
        end

        // en dropped mid-burst: burst completes, then FSM parks in IDLE
        hdr_log.delete();
        load(1, BW); load(2, BW);
        b = 500;
        while (!(m_active && m_data_seen >= 100) && b > 0) begin step(); b--; end
        en = 1'b0;
        run_until(m_count + 1, BW + 100);
        for (int i = 0; i < 40; i++) begin
            step();
            chk("t7_busy", 32'(busy), 32'd0);
            chk("t7_out_valid", 32'(bus.out_valid), 32'd0);
        end
        en = 1'b1;
        b = BW + 100;
        while (!(m_active && m_data_seen >= 2000) && b > 0) begin step(); b--; end
        chk("t7_reached_2000", 32'(m_data_seen), 32'd2000);
        chk("t7_nhdr", 32'(hdr_log.size()), 32'd2);
        if (hdr_log.size() == 2) begin
            chk("t7_first", 32'(hdr_log[0]), 32'd1);
            chk("t7_second", 32'(hdr_log[1]), 32'd2);
        end

        // Reset at word 2000, then the pointer must restart from 0
        do_reset("rst2");
        hdr_log.delete();
        load(1, BW); load(3, BW);
        b = 50;
        while (hdr_log.size() == 0 && b > 0) begin step(); b--; end
        chk("t8_nhdr", 32'(hdr_log.size()), 32'd1);
        if (hdr_log.size() > 0) chk("t8_chan", 32'(hdr_log[0]), 32'd1);
        chk("t8_burst_count", 32'(burst_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
